muldiv_unit: RTL and testbench

- E-stage HI/LO multiply/divide unit; the executing end of the decoder's mulCtrl / mulEnable / mulOutputSel command interface.
- Accepts one command per issue, runs multi-cycle multiply/divide with a registered busy indication, and commits results to HI/LO.
- Serves mfhi/mflo reads combinationally; the hazard unit stalls D/E on busy.

---
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the E stage: latches one command per issue, holds busy for a
// fixed number of cycles, then commits the 64-bit result to HI/LO. mfhi/mflo read combinationally.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mulCtrl,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        mulOutputSel,
  output logic        busy,
  output logic [31:0] result
);

  // mulCtrl encodings, matching the decoder's constants
  localparam logic [3:0] MT_DISABLED = 4'd0;
  localparam logic [3:0] MT_SETHI    = 4'd1;
  localparam logic [3:0] MT_SETLO    = 4'd2;
  localparam logic [3:0] MT_MULT     = 4'd3;
  localparam logic [3:0] MT_MULTU    = 4'd4;
  localparam logic [3:0] MT_MADD     = 4'd5;
  localparam logic [3:0] MT_MADDU    = 4'd6;
  localparam logic [3:0] MT_MSUB     = 4'd7;
  localparam logic [3:0] MT_DIV      = 4'd8;
  localparam logic [3:0] MT_DIVU     = 4'd9;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;

  logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic [63:0] w_prod_s, w_prod_u, w_acc;
  logic [31:0] w_abs_a, w_abs_b, w_dvd, w_dvs, w_q, w_r;
  logic        w_sdiv, w_b_nz;
  logic [31:0] w_hi_nxt, w_lo_nxt;

  assign w_a_sx   = {{32{r_a[31]}}, r_a};
  assign w_b_sx   = {{32{r_b[31]}}, r_b};
  assign w_a_zx   = {32'd0, r_a};
  assign w_b_zx   = {32'd0, r_b};
  // Low 64 bits of the sign-extended product equal the exact signed 64-bit product.
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = w_a_zx * w_b_zx;
  assign w_acc    = {r_hi, r_lo};

  // One unsigned divider serves both div and divu; div works on magnitudes and fixes signs after.
  assign w_sdiv  = (r_op == MT_DIV);
  assign w_b_nz  = (r_b != 32'd0);
  assign w_abs_a = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_abs_b = r_b[31] ? (~r_b + 32'd1) : r_b;
  assign w_dvd   = w_sdiv ? w_abs_a : r_a;
  assign w_dvs   = w_sdiv ? w_abs_b : r_b;
  assign w_q     = w_b_nz ? (w_dvd / w_dvs) : 32'd0;
  assign w_r     = w_b_nz ? (w_dvd % w_dvs) : 32'd0;

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    case (r_op)
      MT_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
      MT_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
      MT_MADD:  {w_hi_nxt, w_lo_nxt} = w_acc + w_prod_s;
      MT_MADDU: {w_hi_nxt, w_lo_nxt} = w_acc + w_prod_u;
      MT_MSUB:  {w_hi_nxt, w_lo_nxt} = w_acc - w_prod_s;
      MT_DIV: begin
        // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000, signs agree.
        if (w_b_nz) begin
          w_lo_nxt = (r_a[31] ^ r_b[31]) ? (~w_q + 32'd1) : w_q;
          w_hi_nxt = r_a[31] ? (~w_r + 32'd1) : w_r;
        end
      end
      MT_DIVU: begin
        if (w_b_nz) begin
          w_lo_nxt = w_q;
          w_hi_nxt = w_r;
        end
      end
      default: begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_op   <= MT_DISABLED;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
    end else if (r_busy) begin
      // Commit on the last busy edge so the result is visible the first cycle busy is low.
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        r_hi   <= w_hi_nxt;
        r_lo   <= w_lo_nxt;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end else if (start) begin
      case (mulCtrl)
        MT_SETHI: r_hi <= operandA;
        MT_SETLO: r_lo <= operandA;
        MT_MULT, MT_MULTU, MT_MADD, MT_MADDU, MT_MSUB: begin
          r_busy <= 1'b1;
          r_cnt  <= MUL_LOAD;
          r_op   <= mulCtrl;
          r_a    <= operandA;
          r_b    <= operandB;
        end
        MT_DIV, MT_DIVU: begin
          r_busy <= 1'b1;
          r_cnt  <= DIV_LOAD;
          r_op   <= mulCtrl;
          r_a    <= operandA;
          r_b    <= operandB;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy   = r_busy;
  assign result = mulOutputSel ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized commands checked
// against a 64-bit integer arithmetic model of HI/LO.
module tb_muldiv_unit;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MTHI  = 4'd1;
  localparam logic [3:0] OP_MTLO  = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_DIV   = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mulCtrl = OP_NOP;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic        mulOutputSel = 1'b0;
  logic        busy;
  logic [31:0] result;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .start(start), .mulCtrl(mulCtrl),
    .operandA(operandA), .operandB(operandB), .mulOutputSel(mulOutputSel),
    .busy(busy), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit integer arithmetic on the architectural HI/LO pair.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] nhi, output logic [31:0] nlo);
    longint sa, sb, q, rm;
    longint unsigned ua, ub, acc, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {hi, lo};
    res = acc;
    case (op)
      OP_MTHI:  res = {a, lo};
      OP_MTLO:  res = {hi, a};
      OP_MULT:  res = longint'(sa * sb);
      OP_MULTU: res = ua * ub;
      OP_MADD:  res = acc + longint'(sa * sb);
      OP_MADDU: res = acc + ua * ub;
      OP_MSUB:  res = acc - longint'(sa * sb);
      OP_DIV:   if (b != 0) begin
                  q = sa / sb;
                  rm = sa % sb;
                  res = {32'(rm), 32'(q)};
                end
      OP_DIVU:  if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
      default:  res = acc;
    endcase
    nhi = res[63:32];
    nlo = res[31:0];
  endfunction

  function automatic int cycles_of(input logic [3:0] op);
    if (op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB}) return MULC;
    if (op inside {OP_DIV, OP_DIVU}) return DIVC;
    return 0;
  endfunction

  // Stimulus helpers (no checking): all start and end at a falling edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mulCtrl = op; operandA = a; operandB = b;
    @(negedge clk);
    start = 1'b0; mulCtrl = OP_NOP;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    mulOutputSel = 1'b1; #1 hi = result;
    mulOutputSel = 1'b0; #1 lo = result;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] hi, output logic [31:0] lo);
    issue(op, a, b);
    measure_busy(n);
    read_hilo(hi, lo);
    model(op, a, b, m_hi, m_lo, m_hi, m_lo);
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    #2;
    read_hilo(hi, lo);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo); end
    @(negedge clk); reset = 1'b1; @(negedge clk);
    read_hilo(hi, lo);
    n_cmp++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
      n_fail++; $display("FAIL post_reset got busy=%b %h_%h want 0", busy, hi, lo); end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_mult();
    int n; logic [31:0] hi, lo;
    run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, n, hi, lo);
    n_cmp++; if (n !== MULC) begin n_fail++; $display("FAIL mult_busy got %0d want %0d", n, MULC); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) begin n_fail++; $display("FAIL mult got %h_%h want ffffffff_fffffffe", hi, lo); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, n, hi, lo);
    n_cmp++; if ({hi, lo} !== 64'h00000001_FFFFFFFE || n !== MULC) begin
      n_fail++; $display("FAIL multu got %h_%h n=%0d want 00000001_fffffffe n=%0d", hi, lo, n, MULC); end
  endtask

  task automatic test_div();
    int n; logic [31:0] hi, lo;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, n, hi, lo);
    n_cmp++; if (n !== DIVC) begin n_fail++; $display("FAIL div_busy got %0d want %0d", n, DIVC); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL div got %h_%h want ffffffff_fffffffd", hi, lo); end
    run_op(OP_DIVU, 32'd7, 32'd2, n, hi, lo);
    n_cmp++; if ({hi, lo} !== 64'h00000001_00000003) begin n_fail++; $display("FAIL divu got %h_%h want 00000001_00000003", hi, lo); end
    run_op(OP_DIV, 32'h12345678, 32'd0, n, hi, lo);
    n_cmp++; if (n !== DIVC || {hi, lo} !== 64'h00000001_00000003) begin
      n_fail++; $display("FAIL div0 got %h_%h n=%0d want 00000001_00000003 n=%0d", hi, lo, n, DIVC); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, n, hi, lo);
    n_cmp++; if ({hi, lo} !== 64'h00000000_80000000) begin n_fail++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_set();
    logic [31:0] hi, lo;
    start = 1'b1; mulCtrl = OP_MTHI; operandA = 32'h12345678;
    @(negedge clk);
    mulCtrl = OP_MTLO; operandA = 32'h9ABCDEF0;
    mulOutputSel = 1'b1; #1;
    n_cmp++; if (busy !== 1'b0 || result !== 32'h12345678) begin
      n_fail++; $display("FAIL mthi got busy=%b hi=%h want 0 12345678", busy, result); end
    @(negedge clk);
    start = 1'b0; mulCtrl = OP_NOP;
    read_hilo(hi, lo);
    n_cmp++; if (busy !== 1'b0 || {hi, lo} !== 64'h12345678_9ABCDEF0) begin
      n_fail++; $display("FAIL mtlo got busy=%b %h_%h want 0 12345678_9abcdef0", busy, hi, lo); end
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
  endtask

  task automatic test_accum();
    int n; logic [31:0] hi, lo;
    run_op(OP_MTHI, 32'd0, 32'd0, n, hi, lo);
    run_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, n, hi, lo);
    run_op(OP_MADD, 32'd1, 32'd1, n, hi, lo);
    n_cmp++; if ({hi, lo} !== 64'h00000001_00000000 || n !== MULC) begin
      n_fail++; $display("FAIL madd got %h_%h n=%0d want 00000001_00000000", hi, lo, n); end
    run_op(OP_MSUB, 32'd1, 32'd1, n, hi, lo);
    n_cmp++; if ({hi, lo} !== 64'h00000000_FFFFFFFF) begin
      n_fail++; $display("FAIL msub got %h_%h want 00000000_ffffffff", hi, lo); end
    run_op(OP_MTLO, 32'd0, 32'd0, n, hi, lo);
    run_op(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, n, hi, lo);
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      n_fail++; $display("FAIL maddu got %h_%h want fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n, total; logic [31:0] hi, lo;
    issue(OP_MULT, 32'd2, 32'd2);
    total = (busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    total += (busy === 1'b1) ? 1 : 0;
    issue(OP_MULT, 32'd3, 32'd3);
    measure_busy(n);
    total += n;
    read_hilo(hi, lo);
    n_cmp++; if (total !== MULC) begin n_fail++; $display("FAIL ignored_busy got %0d want %0d", total, MULC); end
    n_cmp++; if ({hi, lo} !== 64'd4) begin n_fail++; $display("FAIL ignored_result got %h_%h want 0_4", hi, lo); end
    m_hi = 0; m_lo = 4;
    run_op(OP_MULTU, 32'd3, 32'd3, n, hi, lo);
    n_cmp++; if (n !== MULC || {hi, lo} !== 64'd9) begin
      n_fail++; $display("FAIL back_to_back got %h_%h n=%0d want 0_9 n=%0d", hi, lo, n, MULC); end
  endtask

  task automatic test_reset_mid();
    int n; logic [31:0] hi, lo;
    run_op(OP_MTHI, 32'hAAAA5555, 32'd0, n, hi, lo);
    issue(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    read_hilo(hi, lo);
    n_cmp++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid got busy=%b %h_%h want 0 0_0", busy, hi, lo); end
    @(negedge clk); reset = 1'b1;
    repeat (DIVC + 3) @(negedge clk);
    read_hilo(hi, lo);
    n_cmp++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
      n_fail++; $display("FAIL reset_no_commit got busy=%b %h_%h want 0 0_0", busy, hi, lo); end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_random();
    int n; logic [31:0] hi, lo, a, b; logic [3:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 9));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      run_op(op, a, b, n, hi, lo);
      n_cmp++; if (n !== cycles_of(op)) begin
        n_fail++; $display("FAIL rand_busy op=%0d got %0d want %0d", op, n, cycles_of(op)); end
      n_cmp++; if ({hi, lo} !== {m_hi, m_lo}) begin
        n_fail++; $display("FAIL rand_hilo op=%0d a=%h b=%h got %h_%h want %h_%h", op, a, b, hi, lo, m_hi, m_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_set();
    test_accum();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
